// File: rtl/wtm_pkg.sv
// Shared constants and helpers for the Wallace-tree multiplier.
// Row scheduling functions size each reduction layer at elaboration.
package wtm_pkg;

  localparam int WTM_WIDTH = 32;
  localparam int WTM_PW    = 2 * WTM_WIDTH;

  // Rows left after l layers of 3:2 compression starting from n rows.
  function automatic int wtm_rows(int n, int l);
    int r;
    r = n;
    for (int k = 0; k < 64; k++) begin
      if (k < l && r > 2)
        r = r - r / 3;
    end
    return r;
  endfunction

  function automatic int wtm_depth(int n);
    int r;
    int d;
    r = n;
    d = 0;
    for (int k = 0; k < 64; k++) begin
      if (r > 2) begin
        r = r - r / 3;
        d = d + 1;
      end
    end
    return d;
  endfunction

  function automatic int wtm_off(int n, int l);
    return wtm_rows(n, l);
  endfunction

  localparam int WTM_DEPTH = wtm_depth(WTM_WIDTH);

  // Set when bits [2w-1:w-1] are not a pure sign extension.
  function automatic logic wtm_ovf(
    logic [WTM_PW-1:0] p,
    int                w
  );
    logic s;
    logic m;
    s = 1'b0;
    m = 1'b0;
    for (int i = 0; i < WTM_PW; i++) begin
      if (i == w - 1)
        s = p[i];
    end
    for (int i = 0; i < WTM_PW; i++) begin
      if (i >= w && i < 2 * w && p[i] != s)
        m = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/wtm_csa.sv
// Row-wide 3:2 carry-save compressor.
// Carry row is pre-shifted left by one; the top carry is dropped.
module wtm_csa
  import wtm_pkg::*;
#(
  parameter int W = WTM_PW
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);

  assign o_sum = i_a ^ i_b ^ i_c;

  assign o_carry = {
    (i_a[W-2:0] & i_b[W-2:0]) |
    (i_a[W-2:0] & i_c[W-2:0]) |
    (i_b[W-2:0] & i_c[W-2:0]),
    1'b0
  };

endmodule

// File: rtl/wallace_tree_multiplier.sv
// Signed Baugh-Wooley multiplier with Wallace-tree reduction,
// final carry-propagate add and a single output register.
module wallace_tree_multiplier
  import wtm_pkg::*;
#(
  parameter int WIDTH = WTM_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overflow
);

  localparam int PW    = 2 * WIDTH;
  localparam int DEPTH = wtm_depth(WIDTH);

  logic [PW-1:0] w_pp [WIDTH];
  logic [PW-1:0] w_sum;
  logic [PW-1:0] r_product;
  logic          r_overflow;

  // Cross terms of exactly one sign bit are inverted.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    logic [WIDTH-1:0] w_bits;
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
      localparam logic INV =
        ((i == WIDTH - 1) != (j == WIDTH - 1));
      assign w_bits[j] =
        (multiplicand[j] & multiplier[i]) ^ INV;
    end
    if (i == 0) begin : g_row0
      assign w_pp[i] = {
        1'b1,
        {(WIDTH-2){1'b0}},
        1'b1,
        w_bits
      };
    end else begin : g_rown
      assign w_pp[i] = {
        {(WIDTH-i){1'b0}},
        w_bits,
        {i{1'b0}}
      };
    end
  end

  for (genvar l = 0; l < DEPTH; l++) begin : g_layer
    localparam int N  = wtm_rows(WIDTH, l);
    localparam int G  = N / 3;
    localparam int R  = N % 3;
    localparam int NO = 2 * G + R;

    logic [PW-1:0] w_in  [N];
    logic [PW-1:0] w_out [NO];

    for (genvar k = 0; k < N; k++) begin : g_src
      if (l == 0) begin : g_first
        assign w_in[k] = w_pp[k];
      end else begin : g_next
        assign w_in[k] = g_layer[l-1].w_out[k];
      end
    end

    for (genvar g = 0; g < G; g++) begin : g_csa
      wtm_csa #(
        .W (PW)
      ) u_csa (
        .i_a     (w_in[3*g]),
        .i_b     (w_in[3*g+1]),
        .i_c     (w_in[3*g+2]),
        .o_sum   (w_out[2*g]),
        .o_carry (w_out[2*g+1])
      );
    end

    for (genvar r = 0; r < R; r++) begin : g_pass
      assign w_out[2*G+r] = w_in[3*G+r];
    end
  end

  assign w_sum = g_layer[DEPTH-1].w_out[0]
               + g_layer[DEPTH-1].w_out[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_product  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_product  <= w_sum;
      r_overflow <= wtm_ovf(w_sum, WIDTH);
    end
  end

  assign product  = r_product;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_wallace_tree_multiplier.sv
// Directed and random checks of the registered signed multiplier
// against a plain-arithmetic reference.
module tb_wallace_tree_multiplier;

  logic        clk;
  logic        reset;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [63:0] product;
  logic        overflow;

  int n_cmp;
  int n_err;

  wallace_tree_multiplier #(
    .WIDTH (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_p(
    logic [31:0] a,
    logic [31:0] b
  );
    longint x;
    x = longint'($signed(a)) * longint'($signed(b));
    return x;
  endfunction

  function automatic logic ref_o(
    logic [31:0] a,
    logic [31:0] b
  );
    longint x;
    x = longint'($signed(a)) * longint'($signed(b));
    return (x > 64'sd2147483647) || (x < -64'sd2147483648);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] ep,
    input logic        eo
  );
    n_cmp++;
    assert (product === ep) else begin
      n_err++;
      $error("FAIL %s product=%h expected=%h", tag, product, ep);
    end
    n_cmp++;
    assert (overflow === eo) else begin
      n_err++;
      $error("FAIL %s overflow=%b expected=%b", tag, overflow, eo);
    end
  endtask

  // Apply operands, take one edge, check against given values.
  task automatic vec(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] ep,
    input logic        eo
  );
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
    #1;
    chk(tag, ep, eo);
  endtask

  task automatic rvec(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b
  );
    vec(tag, a, b, ref_p(a, b), ref_o(a, b));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    multiplicand = 32'd5;
    multiplier   = 32'd7;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", 64'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_hold2", 64'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_release", 64'd35, 1'b0);

    vec("zero_zero", 32'd0, 32'd0, 64'd0, 1'b0);
    vec("pos_pos", 32'd123, 32'd456, 64'd56088, 1'b0);
    vec("neg_pos", -32'sd123, 32'd456,
        -64'sd56088, 1'b0);
    vec("neg_neg", -32'sd123, -32'sd456,
        64'd56088, 1'b0);
    vec("zero_pos", 32'd0, 32'd456, 64'd0, 1'b0);

    vec("max_max", 32'h7FFFFFFF, 32'h7FFFFFFF,
        64'h3FFFFFFF00000001, 1'b1);
    vec("min_min", 32'h80000000, 32'h80000000,
        64'h4000000000000000, 1'b1);
    vec("min_one", 32'h80000000, 32'd1,
        64'hFFFFFFFF80000000, 1'b0);
    vec("min_m1", 32'h80000000, 32'hFFFFFFFF,
        64'h0000000080000000, 1'b1);

    // Mid-cycle operand change must not reach the outputs.
    vec("hold_pre", 32'd3, 32'd4, 64'd12, 1'b0);
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    #2;
    chk("hold_mid", 64'd12, 1'b0);
    @(posedge clk);
    #1;
    chk("hold_post", 64'd81, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) b = $urandom_range(0, 255);
      rvec("random", a, b);
    end

    // Async reset between edges.
    vec("ar_pre", 32'd11, 32'd13, 64'd143, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_async", 64'd0, 1'b0);
    multiplicand = -32'sd7;
    multiplier   = 32'd6;
    @(posedge clk);
    #1;
    chk("ar_held", 64'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_resume", -64'sd42, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      rvec("ar_random", a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
